effect_executor: RTL and testbench
==================================

// Module: effect_executor
// PURPOSE
//  Consumes the 4-bit opcode stream produced by the breadboard channel sequencer and drives
//  the decoration's actuators: power state, LED colour, sound playback and movement/fog effects.
//  Opcode[3:2] selects the class (00 system, 01 colour, 10 sound, 11 movement); [1:0] selects the item.
//  Sound and movement are timed; the upstream sequencer is stalled through a valid/ready handshake.
// PARAMETERS
//  SOUND_CYCLES  8   clk cycles sound_active stays high per sound op (>=2)
//  MOVE_CYCLES   4   clk cycles a WAVEHANDS/MOVEJAW pulse lasts (>=2)
//  FOG_CYCLES    12  clk cycles fog_on lasts (>=2)
// PORTS
//  clk           in   1  clock; all state on posedge
//  rst           in   1  reset, asynchronous, active-high
//  op_valid      in   1  opcode present this cycle
//  opcode        in   4  opcode from sequencer mux
//  op_ready      out  1  combinational; op accepted when op_valid && op_ready
//  powered       out  1  decoration on
//  color_en      out  1  LEDs lit
//  color_id      out  2  00 GREEN, 01 PURPLE, 10 ORANGE
//  sound_active  out  1  sound playing
//  sound_id      out  2  00 SCREAMING, 01 CACKLING, 10 BOO
//  hands_on      out  1  WAVEHANDS actuator
//  jaw_on        out  1  MOVEJAW actuator
//  fog_on        out  1  fog machine
//  err_count     out  8  illegal opcodes seen, saturating at 255
// BEHAVIOUR
//  - rst: all outputs 0, power FSM = OFF, timers 0.
//  - Power FSM OFF/ON. OFF->ON on accepted 0000 (ON). RESET (0001) from any state: next cycle
//    FSM=OFF, colour/sound/movement outputs and timers cleared; err_count kept (only rst clears it).
//  - In OFF every opcode is accepted (op_ready=1); non-system ops are dropped, no output change.
//  - Illegal ops 0010,0011,0111,1011,1111: accepted in any state, dropped, err_count+1 (sat 255).
//  - Colour (ON): accepted always; next cycle color_en=1, color_id=opcode[1:0]. 1-cycle latency.
//  - Sound (ON): down-counter snd_cnt. Accept loads SOUND_CYCLES; sound_active = (snd_cnt!=0);
//    sound_id latched on accept. op_ready for a sound op = (snd_cnt<=1): accept on final cycle
//    reloads -> back-to-back sounds with no gap; otherwise op_ready=0 (stall, opcode held upstream).
//  - Movement (ON): one shared channel, mv_cnt. WAVEHANDS/MOVEJAW load MOVE_CYCLES, FOG loads
//    FOG_CYCLES; exactly one of hands_on/jaw_on/fog_on high while mv_cnt!=0. Ready rule as sound.
//  - op_ready for system, colour and illegal ops is always 1; sound/movement channels are
//    independent (sound busy never stalls movement and vice-versa).
//  - Simultaneous: RESET accepted while timers running wins; timers cleared, no extra pulse.
//    ON while already ON: no-op. rst mid-effect: immediate async clear.
//  - Opcode with op_valid=0 is ignored entirely.
// STRUCTURE
//  - halloween_pkg: opcode localparams (ON..FOG), class codes, power-state enum.
//  - Sub-module effect_timer #(W): load/load_val/count/busy/last; instantiated for sound
//    and movement channels. Power FSM, decode, err_count in top.
// TESTING
//  1 rst, send GREEN while OFF -> accepted, color_en stays 0; then ON, PURPLE -> color_en=1, id=01 next cycle.
//  2 ON, BOO, hold CACKLING valid -> sound_active 8 cycles id=10, op_ready low 7 cycles,
//    CACKLING accepted on 8th, sound_active continuous 16 cycles total, id=01 from cycle 9.
//  3 ON, FOG then WAVEHANDS -> fog_on 12 cycles, WAVEHANDS stalled 11 cycles, then hands_on 4 cycles;
//    ORANGE issued during stall is accepted immediately (color_id=10).
//  4 ON, SCREAM + MOVEJAW running, send RESET -> next cycle powered=0, all actuators 0, err_count unchanged.
//  5 send 0011 x300 -> err_count increments each accept, saturates at 255; no other output change.
//  6 assert rst mid-sound (cycle 3) -> outputs 0 same cycle, err_count=0, powered=0.

Source files
------------

// File: rtl/halloween_pkg.sv
// Shared opcode map, class codes and power-state type for the decoration effect path.
package halloween_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CLS_W = 2;

    // System class
    localparam logic [OP_W-1:0] OP_ON      = 4'b0000;
    localparam logic [OP_W-1:0] OP_RESET   = 4'b0001;
    // Colour class
    localparam logic [OP_W-1:0] OP_GREEN   = 4'b0100;
    localparam logic [OP_W-1:0] OP_PURPLE  = 4'b0101;
    localparam logic [OP_W-1:0] OP_ORANGE  = 4'b0110;
    // Sound class
    localparam logic [OP_W-1:0] OP_SCREAM  = 4'b1000;
    localparam logic [OP_W-1:0] OP_CACKLE  = 4'b1001;
    localparam logic [OP_W-1:0] OP_BOO     = 4'b1010;
    // Movement class
    localparam logic [OP_W-1:0] OP_WAVE    = 4'b1100;
    localparam logic [OP_W-1:0] OP_JAW     = 4'b1101;
    localparam logic [OP_W-1:0] OP_FOG     = 4'b1110;

    localparam logic [CLS_W-1:0] CLS_SYS   = 2'b00;
    localparam logic [CLS_W-1:0] CLS_COLOR = 2'b01;
    localparam logic [CLS_W-1:0] CLS_SOUND = 2'b10;
    localparam logic [CLS_W-1:0] CLS_MOVE  = 2'b11;

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_t;

    // Item 11 of every class is unused, as is system item 10.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return (op[1:0] == 2'b11) || (op == 4'b0010);
    endfunction

endpackage

// File: rtl/effect_timer.sv
// Loadable down-counter used to time one effect channel; busy while nonzero.
module effect_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         busy,
    output logic         last
);

    logic [W-1:0] cnt;

    // Clear beats load; load beats decrement so a final-cycle reload gives no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy = (cnt != '0);
    assign last = (cnt == W'(1));

endmodule

// File: rtl/effect_executor.sv
// Decodes the sequencer opcode stream and drives power, colour, sound and movement actuators.
module effect_executor
    import halloween_pkg::*;
#(
    parameter int unsigned SOUND_CYCLES = 8,
    parameter int unsigned MOVE_CYCLES  = 4,
    parameter int unsigned FOG_CYCLES   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [3:0] opcode,
    output logic       op_ready,
    output logic       powered,
    output logic       color_en,
    output logic [1:0] color_id,
    output logic       sound_active,
    output logic [1:0] sound_id,
    output logic       hands_on,
    output logic       jaw_on,
    output logic       fog_on,
    output logic [7:0] err_count
);

    localparam int unsigned SND_W  = $clog2(SOUND_CYCLES + 1);
    localparam int unsigned MV_MAX = (MOVE_CYCLES > FOG_CYCLES) ? MOVE_CYCLES : FOG_CYCLES;
    localparam int unsigned MV_W   = $clog2(MV_MAX + 1);

    pwr_state_t        pwr_state;
    logic [CLS_W-1:0]  op_cls;
    logic              op_bad;
    logic              is_on;
    logic              accept;
    logic              sys_reset;
    logic              snd_load;
    logic              mv_load;
    logic              snd_busy;
    logic              snd_last;
    logic              mv_busy;
    logic              mv_last;
    logic [1:0]        mv_sel;
    logic [MV_W-1:0]   mv_load_val;

    assign op_cls = opcode[3:2];
    assign op_bad = is_illegal(opcode);
    assign is_on  = (pwr_state == PWR_ON);

    // Only legal sound/movement ops stall, and only while their own channel is mid-effect.
    always_comb begin
        op_ready = 1'b1;
        if (is_on && !op_bad) begin
            if (op_cls == CLS_SOUND) begin
                op_ready = !snd_busy || snd_last;
            end else if (op_cls == CLS_MOVE) begin
                op_ready = !mv_busy || mv_last;
            end
        end
    end

    assign accept      = op_valid && op_ready;
    assign sys_reset   = accept && (opcode == OP_RESET);
    assign snd_load    = accept && is_on && !op_bad && (op_cls == CLS_SOUND);
    assign mv_load     = accept && is_on && !op_bad && (op_cls == CLS_MOVE);
    assign mv_load_val = (opcode == OP_FOG) ? MV_W'(FOG_CYCLES) : MV_W'(MOVE_CYCLES);

    effect_timer #(.W(SND_W)) u_snd_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (sys_reset),
        .load     (snd_load),
        .load_val (SND_W'(SOUND_CYCLES)),
        .count    (1'b1),
        .busy     (snd_busy),
        .last     (snd_last)
    );

    effect_timer #(.W(MV_W)) u_mv_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (sys_reset),
        .load     (mv_load),
        .load_val (mv_load_val),
        .count    (1'b1),
        .busy     (mv_busy),
        .last     (mv_last)
    );

    // Power FSM plus latched colour, sound id, movement select and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_state <= PWR_OFF;
            color_en  <= 1'b0;
            color_id  <= 2'b00;
            sound_id  <= 2'b00;
            mv_sel    <= 2'b00;
            err_count <= 8'd0;
        end else if (accept) begin
            if (op_bad) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (opcode == OP_RESET) begin
                pwr_state <= PWR_OFF;
                color_en  <= 1'b0;
                color_id  <= 2'b00;
                sound_id  <= 2'b00;
                mv_sel    <= 2'b00;
            end else if (opcode == OP_ON) begin
                pwr_state <= PWR_ON;
            end else if (is_on) begin
                case (op_cls)
                    CLS_COLOR: begin
                        color_en <= 1'b1;
                        color_id <= opcode[1:0];
                    end
                    CLS_SOUND: sound_id <= opcode[1:0];
                    CLS_MOVE:  mv_sel   <= opcode[1:0];
                    default:   ;
                endcase
            end
        end
    end

    assign powered      = is_on;
    assign sound_active = snd_busy;
    assign hands_on     = mv_busy && (mv_sel == 2'b00);
    assign jaw_on       = mv_busy && (mv_sel == 2'b01);
    assign fog_on       = mv_busy && (mv_sel == 2'b10);

endmodule

// File: tb/tb_effect_executor.sv
// Directed self-checking bench for effect_executor.
module tb_effect_executor;

    logic       clk;
    logic       rst;
    logic       op_valid;
    logic [3:0] opcode;
    logic       op_ready;
    logic       powered;
    logic       color_en;
    logic [1:0] color_id;
    logic       sound_active;
    logic [1:0] sound_id;
    logic       hands_on;
    logic       jaw_on;
    logic       fog_on;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err;

    effect_executor dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .opcode       (opcode),
        .op_ready     (op_ready),
        .powered      (powered),
        .color_en     (color_en),
        .color_id     (color_id),
        .sound_active (sound_active),
        .sound_id     (sound_id),
        .hands_on     (hands_on),
        .jaw_on       (jaw_on),
        .fog_on       (fog_on),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present op until accepted (bounded), return 1 ns after the accepting edge.
    task automatic send(input logic [3:0] op);
        op_valid = 1'b1;
        opcode   = op;
        #1;
        for (int k = 0; k < 64 && !op_ready; k++) begin
            tick();
        end
        if (!op_ready) check("send_timeout", 0, 1);
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        opcode   = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // 1: reset state, colour ignored while OFF, then ON + PURPLE
        check("rst_powered", int'(powered), 0);
        check("rst_color_en", int'(color_en), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_sound", int'(sound_active), 0);
        check("off_ready", int'(op_ready), 1);
        send(4'b0100);
        check("off_green_color_en", int'(color_en), 0);
        check("off_green_powered", int'(powered), 0);
        send(4'b0000);
        check("on_powered", int'(powered), 1);
        send(4'b0101);
        check("purple_en", int'(color_en), 1);
        check("purple_id", int'(color_id), 1);

        // 2: BOO then CACKLING held back-to-back
        send(4'b1010);
        op_valid = 1'b1;
        opcode   = 4'b1001;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("boo_active", int'(sound_active), 1);
            check("boo_id", int'(sound_id), 2);
            check("boo_ready", int'(op_ready), (i == 7) ? 1 : 0);
            tick();
        end
        op_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("cackle_active", int'(sound_active), 1);
            check("cackle_id", int'(sound_id), 1);
            tick();
        end
        check("sound_done", int'(sound_active), 0);

        // 3: FOG, WAVEHANDS stalled, ORANGE slips through mid-stall
        send(4'b1110);
        op_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("fog_on", int'(fog_on), 1);
            check("fog_hands_off", int'(hands_on), 0);
            if (i == 6) begin
                check("orange_en", int'(color_en), 1);
                check("orange_id", int'(color_id), 2);
            end
            opcode = (i == 5) ? 4'b0110 : 4'b1100;
            #1;
            check("fog_ready", int'(op_ready), (i == 5 || i == 11) ? 1 : 0);
            tick();
        end
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hands_on", int'(hands_on), 1);
            check("hands_fog_off", int'(fog_on), 0);
            tick();
        end
        check("hands_done", int'(hands_on), 0);

        // 4: RESET while sound + jaw run; err_count survives
        send(4'b0111);
        check("err_one", int'(err_count), 1);
        send(4'b1000);
        send(4'b1101);
        check("jaw_on", int'(jaw_on), 1);
        check("scream_active", int'(sound_active), 1);
        check("sound_indep_ready", int'(sound_id), 0);
        send(4'b0001);
        check("reset_powered", int'(powered), 0);
        check("reset_sound", int'(sound_active), 0);
        check("reset_jaw", int'(jaw_on), 0);
        check("reset_color_en", int'(color_en), 0);
        check("reset_err_kept", int'(err_count), 1);
        tick();
        check("reset_no_pulse", int'(jaw_on | sound_active | fog_on | hands_on), 0);

        // 5: illegal op flood saturates err_count
        exp_err = 1;
        for (int i = 0; i < 300; i++) begin
            send(4'b0011);
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
            check("err_count", int'(err_count), exp_err);
        end
        check("flood_powered", int'(powered), 0);
        check("flood_color_en", int'(color_en), 0);

        // 6: async rst mid-sound
        send(4'b0000);
        send(4'b1000);
        tick();
        tick();
        check("pre_rst_active", int'(sound_active), 1);
        rst = 1'b1;
        #1;
        check("arst_active", int'(sound_active), 0);
        check("arst_powered", int'(powered), 0);
        check("arst_err", int'(err_count), 0);
        tick();
        rst = 1'b0;

        // op_valid low: opcode ignored
        opcode = 4'b0000;
        tick();
        tick();
        check("invalid_ignored", int'(powered), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
